count_event_tracker: RTL and testbench

//  Downstream observer of the 4-bit loadable up/down counter. Taps the counter's load/ud/data_in

---
 rtl/count_trk_pkg.sv | 16 +
 rtl/count_event_tracker_if.sv | 15 +
 rtl/count_trk_fifo.sv | 43 ++++
 rtl/count_event_tracker.sv | 136 +++++++++++++
 tb/tb_count_event_tracker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/count_trk_pkg.sv
// rtl/count_trk_pkg.sv - shared types for the counter event tracker
package count_trk_pkg;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        EVT_LOAD    = 2'd0,
        EVT_WRAP_UP = 2'd1,
        EVT_WRAP_DN = 2'd2,
        EVT_ILLEGAL = 2'd3
    } evt_t;

    typedef struct packed {
        evt_t             typ;
        logic [CNT_W-1:0] val;
    } evt_rec_t;
endpackage

// File: rtl/count_event_tracker_if.sv
// rtl/count_event_tracker_if.sv - event record valid/ready stream
interface count_event_tracker_if #(
    parameter int TS_W = 16
);
    import count_trk_pkg::*;

    logic             evt_valid;
    logic             evt_ready;
    evt_t             evt_type;
    logic [CNT_W-1:0] evt_value;
    logic [TS_W-1:0]  evt_ts;

    modport master (output evt_valid, evt_type, evt_value, evt_ts, input evt_ready);
    modport slave  (input evt_valid, evt_type, evt_value, evt_ts, output evt_ready);
endinterface

// File: rtl/count_trk_fifo.sv
// rtl/count_trk_fifo.sv - synchronous FIFO; a full FIFO accepts a push when it is also popped
module count_trk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/count_event_tracker.sv
// rtl/count_event_tracker.sv - checks each counter step, extends the count, queues events
module count_event_tracker
    import count_trk_pkg::*;
#(
    parameter int EXT_W = 8,
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cnt_load,
    input  logic                   cnt_ud,
    input  logic [CNT_W-1:0]       cnt_data_in,
    input  logic [CNT_W-1:0]       cnt_data_out,
    output logic [EXT_W+CNT_W-1:0] ext_count,
    count_event_tracker_if.master  evt,
    output logic                   err_sticky,
    output logic                   ovf_sticky,
    output logic [7:0]             drop_cnt
);
    localparam int REC_W = $bits(evt_rec_t);
    localparam int FIFO_W = REC_W + TS_W;
    localparam logic [EXT_W-1:0] EXT_ONE = 1;
    localparam logic [TS_W-1:0]  TS_ONE  = 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] din_q;
    logic             load_q;
    logic             ud_q;
    logic             prev_valid;
    logic [EXT_W-1:0] ext_q;
    logic [EXT_W-1:0] ext_nxt;
    logic [TS_W-1:0]  ts;

    logic [CNT_W-1:0] step_up;
    logic [CNT_W-1:0] step_dn;
    logic             push;
    evt_rec_t         rec;

    logic [FIFO_W-1:0] head;
    evt_rec_t          head_rec;
    logic              empty;
    logic              full;
    logic              drop;

    assign step_up = cnt_q + 4'd1;
    assign step_dn = cnt_q - 4'd1;

    // Load outranks direction; a step that matches neither rule is ILLEGAL.
    always_comb begin
        push    = 1'b0;
        rec     = '{typ: EVT_LOAD, val: cnt_data_out};
        ext_nxt = ext_q;
        if (prev_valid) begin
            if (load_q) begin
                push = 1'b1;
                if (cnt_data_out == din_q) begin
                    rec.typ = EVT_LOAD;
                    ext_nxt = '0;
                end else begin
                    rec.typ = EVT_ILLEGAL;
                end
            end else if (ud_q) begin
                if (cnt_data_out != step_up) begin
                    push    = 1'b1;
                    rec.typ = EVT_ILLEGAL;
                end else if (cnt_q == 4'hF) begin
                    push    = 1'b1;
                    rec.typ = EVT_WRAP_UP;
                    ext_nxt = ext_q + EXT_ONE;
                end
            end else begin
                if (cnt_data_out != step_dn) begin
                    push    = 1'b1;
                    rec.typ = EVT_ILLEGAL;
                end else if (cnt_q == 4'h0) begin
                    push    = 1'b1;
                    rec.typ = EVT_WRAP_DN;
                    ext_nxt = ext_q - EXT_ONE;
                end
            end
        end
    end

    // A full FIFO still accepts the push when the consumer takes the head this cycle.
    assign drop = push && full && !evt.evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            din_q      <= '0;
            load_q     <= 1'b0;
            ud_q       <= 1'b0;
            prev_valid <= 1'b0;
            ext_q      <= '0;
            ts         <= '0;
            err_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            cnt_q      <= cnt_data_out;
            din_q      <= cnt_data_in;
            load_q     <= cnt_load;
            ud_q       <= cnt_ud;
            prev_valid <= 1'b1;
            ext_q      <= prev_valid ? ext_nxt : '0;
            ts         <= ts + TS_ONE;
            if (push && rec.typ == EVT_ILLEGAL) err_sticky <= 1'b1;
            if (drop) begin
                ovf_sticky <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    count_trk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({rec, ts}),
        .pop   (evt.evt_ready),
        .rdata (head),
        .empty (empty),
        .full  (full)
    );

    assign head_rec      = evt_rec_t'(head[FIFO_W-1:TS_W]);
    assign ext_count     = {ext_q, cnt_q};
    assign evt.evt_valid = !empty;
    assign evt.evt_type  = empty ? EVT_LOAD : head_rec.typ;
    assign evt.evt_value = empty ? '0 : head_rec.val;
    assign evt.evt_ts    = empty ? '0 : head[TS_W-1:0];
endmodule

// File: tb/tb_count_event_tracker.sv
// tb/tb_count_event_tracker.sv - directed vector bench for count_event_tracker
module tb_count_event_tracker;
    import count_trk_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_load;
    logic        cnt_ud;
    logic [3:0]  cnt_data_in;
    logic [3:0]  cnt_data_out;
    logic [11:0] ext_count;
    logic        err_sticky;
    logic        ovf_sticky;
    logic [7:0]  drop_cnt;

    logic [3:0]  mcnt;
    logic        bad;
    logic [3:0]  bad_val;
    int          n_vec = 0;
    int          n_bad = 0;

    count_event_tracker_if #(.TS_W(16)) evt_if ();

    count_event_tracker #(.EXT_W(8), .DEPTH(4), .TS_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt_load     (cnt_load),
        .cnt_ud       (cnt_ud),
        .cnt_data_in  (cnt_data_in),
        .cnt_data_out (cnt_data_out),
        .ext_count    (ext_count),
        .evt          (evt_if),
        .err_sticky   (err_sticky),
        .ovf_sticky   (ovf_sticky),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the observed 4-bit loadable up/down counter.
    always @(posedge clk) begin
        if (reset)         mcnt <= 4'h0;
        else if (cnt_load) mcnt <= cnt_data_in;
        else if (cnt_ud)   mcnt <= mcnt + 4'd1;
        else               mcnt <= mcnt - 4'd1;
    end
    assign cnt_data_out = bad ? bad_val : mcnt;

    typedef struct {
        int          n;
        logic        load;
        logic        ud;
        logic        bad;
        logic [3:0]  din;
        logic [3:0]  bad_val;
        logic        ev;
        logic [1:0]  et;
        logic [3:0]  evl;
        logic [15:0] ets;
        logic [11:0] ext;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_head(input string nm, input logic [1:0] et, input logic [3:0] ev);
        chk({nm, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
        chk({nm, ".type"},  32'(evt_if.evt_type),  32'(et));
        chk({nm, ".value"}, 32'(evt_if.evt_value), 32'(ev));
    endtask

    initial begin
        reset = 1'b1; cnt_load = 1'b0; cnt_ud = 1'b1; cnt_data_in = 4'h0;
        bad = 1'b0; bad_val = 4'h0; evt_if.evt_ready = 1'b1;

        //        n   ld ud bad din   bval  ev et vl  ts   ext      err
        vt.push_back('{1,  0, 1, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h000, 0});
        vt.push_back('{15, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h00F, 0});
        vt.push_back('{1,  0, 1, 0, 4'h0, 4'h0, 1, 1, 0,  16, 12'h010, 0});
        vt.push_back('{1,  0, 1, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h011, 0});
        vt.push_back('{2,  0, 1, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h013, 0});
        vt.push_back('{1,  1, 1, 0, 4'hA, 4'h0, 0, 0, 0,  0,  12'h014, 0});
        vt.push_back('{1,  0, 0, 0, 4'h0, 4'h0, 1, 0, 10, 21, 12'h00A, 0});
        vt.push_back('{1,  0, 0, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h009, 0});
        vt.push_back('{9,  0, 0, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h000, 0});
        vt.push_back('{1,  0, 0, 0, 4'h0, 4'h0, 1, 2, 15, 32, 12'hFFF, 0});
        vt.push_back('{1,  0, 0, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'hFFE, 0});
        vt.push_back('{1,  1, 0, 0, 4'h5, 4'h0, 0, 0, 0,  0,  12'hFFD, 0});
        vt.push_back('{1,  1, 1, 1, 4'h7, 4'h6, 1, 3, 6,  35, 12'hFF6, 1});
        vt.push_back('{1,  0, 1, 0, 4'h0, 4'h0, 1, 0, 7,  36, 12'h007, 1});
        vt.push_back('{1,  0, 1, 0, 4'h0, 4'h0, 0, 0, 0,  0,  12'h008, 1});

        step();
        step();
        chk("rst.ext", 32'(ext_count), 32'h0);
        chk("rst.valid", 32'(evt_if.evt_valid), 32'h0);
        chk("rst.err", 32'(err_sticky), 32'h0);
        chk("rst.ovf", 32'(ovf_sticky), 32'h0);
        chk("rst.drop", 32'(drop_cnt), 32'h0);
        chk("rst.ts", 32'(evt_if.evt_ts), 32'h0);

        reset = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            cnt_load = vt[i].load; cnt_ud = vt[i].ud; cnt_data_in = vt[i].din;
            bad = vt[i].bad; bad_val = vt[i].bad_val;
            repeat (vt[i].n) step();
            chk($sformatf("v%0d.ext", i), 32'(ext_count), 32'(vt[i].ext));
            chk($sformatf("v%0d.valid", i), 32'(evt_if.evt_valid), 32'(vt[i].ev));
            chk($sformatf("v%0d.err", i), 32'(err_sticky), 32'(vt[i].err));
            if (vt[i].ev) begin
                chk($sformatf("v%0d.type", i), 32'(evt_if.evt_type), 32'(vt[i].et));
                chk($sformatf("v%0d.value", i), 32'(evt_if.evt_value), 32'(vt[i].evl));
                chk($sformatf("v%0d.ts", i), 32'(evt_if.evt_ts), 32'(vt[i].ets));
            end
        end
        bad = 1'b0;
        chk("tbl.ovf", 32'(ovf_sticky), 32'h0);

        // Overflow: six loads into a four-deep queue with no consumer.
        evt_if.evt_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cnt_load = 1'b1; cnt_data_in = 4'(i);
            step();
        end
        cnt_load = 1'b0; cnt_ud = 1'b1;
        step();
        chk("ovf.drop", 32'(drop_cnt), 32'd2);
        chk("ovf.sticky", 32'(ovf_sticky), 32'd1);
        chk("ovf.ext", 32'(ext_count), 32'h006);
        evt_if.evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk_head($sformatf("drain%0d", i), 2'(EVT_LOAD), 4'(i));
            step();
        end
        chk("drain.empty", 32'(evt_if.evt_valid), 32'd0);

        // Full queue: pop and new event on the same edge.
        evt_if.evt_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cnt_load = 1'b1; cnt_data_in = 4'(i);
            step();
        end
        chk_head("full.head", 2'(EVT_LOAD), 4'd1);
        cnt_load = 1'b0; cnt_ud = 1'b1; evt_if.evt_ready = 1'b1;
        step();
        chk("pp.drop", 32'(drop_cnt), 32'd2);
        for (int i = 2; i <= 5; i++) begin
            chk_head($sformatf("pp%0d", i), 2'(EVT_LOAD), 4'(i));
            step();
        end
        chk("pp.empty", 32'(evt_if.evt_valid), 32'd0);

        // Reset with three events queued.
        evt_if.evt_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cnt_load = 1'b1; cnt_data_in = 4'(i);
            step();
        end
        cnt_load = 1'b0;
        step();
        chk_head("pre_rst.head", 2'(EVT_LOAD), 4'd1);
        chk("pre_rst.err", 32'(err_sticky), 32'd1);
        reset = 1'b1; cnt_load = 1'b1; cnt_data_in = 4'h9;
        step();
        chk("mid_rst.valid", 32'(evt_if.evt_valid), 32'd0);
        chk("mid_rst.ext", 32'(ext_count), 32'h0);
        chk("mid_rst.err", 32'(err_sticky), 32'd0);
        chk("mid_rst.ovf", 32'(ovf_sticky), 32'd0);
        chk("mid_rst.drop", 32'(drop_cnt), 32'd0);
        reset = 1'b0; cnt_load = 1'b0; cnt_ud = 1'b1;
        step();
        chk("post_rst1.valid", 32'(evt_if.evt_valid), 32'd0);
        chk("post_rst1.ext", 32'(ext_count), 32'h000);
        step();
        chk("post_rst2.valid", 32'(evt_if.evt_valid), 32'd0);
        chk("post_rst2.ext", 32'(ext_count), 32'h001);
        chk("post_rst2.err", 32'(err_sticky), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
